ftoi_pipe: RTL and testbench

// - Pipelined IEEE-754 single -> signed int32 converter; inverse of itof.
// - Consumes float results (e.g. itof output) and returns integers to the integer datapath.
// - 2-stage pipeline, valid/ready handshake both sides, 1 result/cycle at full throughput.

---
 rtl/ftoi_pipe.sv | 160 ++++++++++++++++
 tb/tb_ftoi_pipe.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ftoi_pipe.sv
// ftoi_pipe
// Two-stage pipelined IEEE-754 single precision -> signed int32 converter.
// Rounds to nearest with ties away from zero and saturates NaN, infinity and
// out-of-range inputs, flagging those with out_ovf.
//
// Ports
//   clk        clock, all state on the rising edge
//   rst        asynchronous active-high reset
//   in_valid   in_data holds a float this cycle
//   in_ready   stage 1 accepts in_data this cycle (combinational)
//   in_data    float: [31] sign, [30:23] biased exponent, [22:0] mantissa
//   out_valid  out_data/out_ovf hold a result
//   out_ready  consumer accepts the result this cycle
//   out_data   signed int32 result
//   out_ovf    result was saturated
module ftoi_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_ovf
);

    // Input classes decided in stage 1 so stage 2 only has to shift and round.
    typedef enum logic [2:0] {
        CLS_ZERO,   // zero, denormal or |x| < 0.5
        CLS_HALF,   // 0.5 <= |x| < 1, always rounds to magnitude 1
        CLS_NORM,   // 1 <= |x| < 2^31
        CLS_SAT,    // infinity or |x| >= 2^31, saturate by sign
        CLS_NAN,    // NaN, saturates positive
        CLS_MIN     // exactly -2^31, representable without saturation
    } cls_t;

    logic        s2_adv;
    logic        s1_adv;

    logic [7:0]  in_exp;
    logic [22:0] in_mant;
    cls_t        cls_d;
    logic [4:0]  shift_d;

    logic        s1_valid;
    logic        s1_sign;
    cls_t        s1_cls;
    logic [23:0] s1_sig;
    logic [4:0]  s1_shift;

    logic [31:0] sig32;
    logic [31:0] mag;
    logic        rnd;
    logic [31:0] mag_r;
    logic [31:0] res_d;
    logic        ovf_d;

    // A stage may advance when whatever it holds can move forward or is a bubble.
    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    assign in_exp  = in_data[30:23];
    assign in_mant = in_data[22:0];

    // Stage 1 decode. For exponents 127..157 the unbiased value exp-127 lies in
    // 0..30, and modulo 32 that equals exp[4:0]+1, which avoids a wide subtract.
    always_comb begin
        cls_d   = CLS_ZERO;
        shift_d = 5'd0;
        if (in_exp == 8'd255) begin
            cls_d = (in_mant != 23'd0) ? CLS_NAN : CLS_SAT;
        end else if (in_exp >= 8'd158) begin
            cls_d = (in_data == 32'hCF00_0000) ? CLS_MIN : CLS_SAT;
        end else if (in_exp >= 8'd127) begin
            cls_d   = CLS_NORM;
            shift_d = in_exp[4:0] + 5'd1;
        end else if (in_exp == 8'd126) begin
            cls_d = CLS_HALF;
        end
    end

    // Stage 1 registers: valid follows the handshake, payload loads only when
    // a new item is actually accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_cls   <= CLS_ZERO;
            s1_sig   <= 24'd0;
            s1_shift <= 5'd0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign  <= in_data[31];
                s1_cls   <= cls_d;
                s1_sig   <= {1'b1, in_mant};
                s1_shift <= shift_d;
            end
        end
    end

    assign sig32 = {8'd0, s1_sig};

    // Stage 2 magnitude: the binary point of sig sits after bit 23, so a
    // shift of 23 means the significand is already the integer value. Right
    // shifts keep the first discarded bit for rounding; ties go away from zero
    // because the rounding is applied to the magnitude before the sign.
    always_comb begin
        mag = 32'd0;
        rnd = 1'b0;
        if (s1_cls == CLS_NORM) begin
            if (s1_shift >= 5'd23) begin
                mag = sig32 << (s1_shift - 5'd23);
            end else begin
                mag = sig32 >> (5'd23 - s1_shift);
                rnd = s1_sig[5'd22 - s1_shift];
            end
        end else if (s1_cls == CLS_HALF) begin
            rnd = 1'b1;
        end
        mag_r = mag + {31'd0, rnd};
    end

    // Stage 2 sign application and saturation.
    always_comb begin
        res_d = 32'd0;
        ovf_d = 1'b0;
        case (s1_cls)
            CLS_NORM, CLS_HALF: res_d = s1_sign ? (32'd0 - mag_r) : mag_r;
            CLS_SAT: begin
                res_d = s1_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
                ovf_d = 1'b1;
            end
            CLS_NAN: begin
                res_d = 32'h7FFF_FFFF;
                ovf_d = 1'b1;
            end
            CLS_MIN: res_d = 32'h8000_0000;
            default: res_d = 32'd0;
        endcase
    end

    // Output registers hold their value while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= 32'd0;
            out_ovf   <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= res_d;
                out_ovf  <= ovf_d;
            end
        end
    end

endmodule

// File: tb/tb_ftoi_pipe.sv
// tb_ftoi_pipe
// Self-checking bench for ftoi_pipe. A real-arithmetic reference model
// predicts every accepted input; a negedge monitor compares each delivered
// result against it, plus hand-computed literals for the directed vectors.
module tb_ftoi_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_ovf;

    ftoi_pipe u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ovf  (out_ovf)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        o;
        bit          has_lit;
        logic [31:0] lit_d;
        logic        lit_o;
        int          cyc;
    } item_t;

    item_t       sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    bit          lat_mode = 0;
    bit          last_acc = 0;
    bit          pend_has_lit = 0;
    logic [31:0] pend_lit_d = 32'd0;
    logic        pend_lit_o = 1'b0;

    // Reference: value = 1.mant * 2^(exp-127), nearest with ties away from
    // zero on the magnitude, then clamp to the int32 range.
    function automatic void model(input logic [31:0] f, output logic [31:0] d, output logic o);
        int     ex;
        real    a;
        real    r;
        longint li;
        ex = int'(f[30:23]);
        d  = 32'd0;
        o  = 1'b0;
        if (ex == 255) begin
            o = 1'b1;
            if (f[22:0] != 23'd0) d = 32'h7FFF_FFFF;
            else d = f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            a = 0.0;
            if (ex != 0) a = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** (real'(ex) - 127.0));
            r = $floor(a + 0.5);
            if (!f[31] && r >= 2147483648.0) begin
                d = 32'h7FFF_FFFF;
                o = 1'b1;
            end else if (f[31] && r > 2147483648.0) begin
                d = 32'h8000_0000;
                o = 1'b1;
            end else begin
                li = longint'(r);
                if (f[31]) li = -li;
                d = li[31:0];
            end
        end
    endfunction

    // Exact int -> float for |k| < 2^24.
    function automatic logic [31:0] itof(input int k);
        logic [31:0] m;
        logic [31:0] m32;
        int          p;
        if (k == 0) return 32'd0;
        m = (k < 0) ? 32'(-k) : 32'(k);
        p = 0;
        for (int i = 0; i < 32; i++) if (m[i]) p = i;
        m32 = m << (23 - p);
        return {(k < 0), 8'(127 + p), m32[22:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: at each negedge the inputs and outputs are stable for the
    // coming edge, so handshakes are recorded here and results are checked.
    bit          prev_stall = 0;
    logic [31:0] prev_d = 32'd0;
    logic        prev_o = 1'b0;
    always @(negedge clk) begin
        item_t it;
        cyc++;
        last_acc = 0;
        if (rst) begin
            sb.delete();
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                checkOutput("stall_valid", 32'(out_valid), 32'd1);
                checkOutput("stall_data", out_data, prev_d);
                checkOutput("stall_ovf", 32'(out_ovf), 32'(prev_o));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_out", 32'(out_valid), 32'd0);
                end else begin
                    it = sb.pop_front();
                    checkOutput("model_data", out_data, it.d);
                    checkOutput("model_ovf", 32'(out_ovf), 32'(it.o));
                    if (it.has_lit) begin
                        checkOutput("lit_data", out_data, it.lit_d);
                        checkOutput("lit_ovf", 32'(out_ovf), 32'(it.lit_o));
                    end
                    if (lat_mode) checkOutput("latency", 32'(cyc - it.cyc), 32'd2);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
            prev_o     = out_ovf;
            if (in_valid && in_ready) begin
                model(in_data, it.d, it.o);
                it.has_lit = pend_has_lit;
                it.lit_d   = pend_lit_d;
                it.lit_o   = pend_lit_o;
                it.cyc     = cyc;
                sb.push_back(it);
                last_acc = 1;
            end
        end
    end

    // Present one float and hold it until accepted; returns cycles taken.
    task automatic applyStimulus(input logic [31:0] f, input bit hl, input logic [31:0] ld,
                                 input logic lo, output int waited);
        in_valid     = 1'b1;
        in_data      = f;
        pend_has_lit = hl;
        pend_lit_d   = ld;
        pend_lit_o   = lo;
        waited       = 0;
        do begin
            @(posedge clk);
            #1;
            waited++;
        end while (!last_acc && waited < 50);
        if (!last_acc) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout actual=none required=accept data=%h", f);
        end
        pend_has_lit = 0;
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        checkOutput("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    logic [31:0] vf[19] = '{32'h3FC00000, 32'hC0200000, 32'h3EFFFFFF, 32'h3F000000, 32'hBF000000,
                            32'h80000000, 32'h4EFFFFFF, 32'h4F000000, 32'hCF000000, 32'hCF000001,
                            32'h7FC00000, 32'hFF800000, 32'h7F800000, 32'h00000001, 32'h40200000,
                            32'h3FBFFFFF, 32'h4B000001, 32'h4E000000, 32'hFFC00000};
    logic [31:0] vd[19] = '{32'h00000002, 32'hFFFFFFFD, 32'h00000000, 32'h00000001, 32'hFFFFFFFF,
                            32'h00000000, 32'h7FFFFF80, 32'h7FFFFFFF, 32'h80000000, 32'h80000000,
                            32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h00000000, 32'h00000003,
                            32'h00000001, 32'h00800001, 32'h20000000, 32'h7FFFFFFF};
    logic        vo[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                            1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] specials[8] = '{32'h7F800000, 32'hFF800000, 32'h7FC00001, 32'hCF000000,
                                 32'h4F000000, 32'h80000000, 32'h3F000000, 32'hBEFFFFFF};

    initial begin
        int          w;
        int          idx;
        int          n;
        int          guard;
        logic [31:0] md;
        logic        mo;
        logic [31:0] bp[3];
        logic [31:0] rf;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        out_ready = 1'b1;
        #1;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_data", out_data, 32'd0);
        checkOutput("reset_out_ovf", 32'(out_ovf), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);

        // Pin the reference model on a few hand-computed points.
        model(32'h3FC00000, md, mo);
        checkOutput("model_pin_1p5", md, 32'd2);
        model(32'hC0200000, md, mo);
        checkOutput("model_pin_m2p5", md, 32'hFFFFFFFD);
        model(32'hCF000001, md, mo);
        checkOutput("model_pin_sat", {md[31:1], mo}, {31'h40000000, 1'b1});
        checkOutput("model_pin_itof", itof(-100), 32'hC2C80000);

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] directed vectors");
        for (int i = 0; i < 19; i++) applyStimulus(vf[i], 1, vd[i], vo[i], w);
        drain();

        $display("[TB] full-throughput sweep");
        lat_mode = 1;
        for (int k = -100; k < 100; k++) begin
            applyStimulus(itof(k), 1, 32'(k), 1'b0, w);
            checkOutput("tp_accept_cycles", 32'(w), 32'd1);
        end
        drain();
        lat_mode = 0;

        $display("[TB] backpressure");
        bp[0] = itof(7);
        bp[1] = itof(-8);
        bp[2] = 32'h3FC00000;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = bp[0];
        idx = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (last_acc && idx < 3) begin
                idx++;
                if (idx < 3) in_data = bp[idx];
            end
        end
        checkOutput("bp_accepted", 32'(idx), 32'd2);
        checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
        checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
        checkOutput("bp_head_data", out_data, 32'd7);
        out_ready = 1'b1;
        applyStimulus(bp[2], 1, 32'd2, 1'b0, w);
        drain();

        $display("[TB] reset mid-stream");
        out_ready = 1'b0;
        applyStimulus(itof(5), 0, 32'd0, 1'b0, w);
        applyStimulus(itof(6), 0, 32'd0, 1'b0, w);
        in_valid = 1'b0;
        checkOutput("full_out_valid", 32'(out_valid), 32'd1);
        checkOutput("full_in_ready", 32'(in_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_out_valid", 32'(out_valid), 32'd0);
        checkOutput("async_out_data", out_data, 32'd0);
        checkOutput("async_out_ovf", 32'(out_ovf), 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            checkOutput("post_reset_idle", 32'(out_valid), 32'd0);
        end
        applyStimulus(itof(42), 1, 32'd42, 1'b0, w);
        drain();

        $display("[TB] random traffic");
        n = 0;
        guard = 0;
        in_valid = 1'b0;
        while (n < 1000 && guard < 20000) begin
            case ($urandom_range(3))
                0: rf = itof(int'($urandom_range(2000000)) - 1000000);
                1: rf = {1'($urandom_range(1)), 8'($urandom_range(160, 120)), 23'($urandom)};
                2: rf = specials[$urandom_range(7)];
                default: rf = $urandom;
            endcase
            in_valid  = ($urandom_range(3) != 0);
            in_data   = rf;
            out_ready = ($urandom_range(2) != 0);
            @(posedge clk);
            #1;
            if (last_acc) n++;
            guard++;
        end
        checkOutput("random_items", 32'(n), 32'd1000);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
